// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified memory port arbiter.
// Imported by the arbiter top.
package mem_port_arbiter_pkg;

   typedef enum logic [1:0] {
      Idle,
      InstBusy,
      DataBusy,
      InstDrop
   } arb_state_t;

   typedef enum logic {
      OwnerInst,
      OwnerData
   } arb_owner_t;

   localparam int CNT_W = 4;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between instruction fetch and data access.
// Data has priority, bounded by a starvation counter that forces an inst grant.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int DATA_SIZE    = 32,
   parameter int ADDR_SIZE    = 32,
   parameter int BYTE_NUM     = DATA_SIZE / 8,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic                 inst_rd_en,
   input  logic [ADDR_SIZE-1:0] inst_addr,
   input  logic                 inst_flush,
   output logic                 inst_ack,
   output logic [DATA_SIZE-1:0] inst_rd_data,
   input  logic                 data_rd_en,
   input  logic                 data_wr_en,
   input  logic [BYTE_NUM-1:0]  data_byte_en,
   input  logic [ADDR_SIZE-1:0] data_addr,
   input  logic [DATA_SIZE-1:0] data_wr_data,
   output logic                 data_ack,
   output logic [DATA_SIZE-1:0] data_rd_data,
   output logic                 mem_rd_en,
   output logic                 mem_wr_en,
   output logic [BYTE_NUM-1:0]  mem_byte_en,
   output logic [ADDR_SIZE-1:0] mem_addr,
   output logic [DATA_SIZE-1:0] mem_wr_data,
   input  logic [DATA_SIZE-1:0] mem_rd_data,
   input  logic                 mem_ack,
   output logic                 wait_if,
   output logic                 wait_mem
);

   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

   arb_state_t           state_q;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 rd_q, wr_q;
   logic [BYTE_NUM-1:0]  be_q;
   logic [ADDR_SIZE-1:0] addr_q;
   logic [DATA_SIZE-1:0] wd_q;

   logic       data_req;
   logic       inst_elig;
   logic       arb_en;
   logic       gnt_vld;
   arb_owner_t gnt_own;

   assign data_req  = data_rd_en | data_wr_en;
   assign inst_elig = inst_rd_en & ~inst_flush;
   // Busy states re-arbitrate on the ack cycle so grants run back to back.
   assign arb_en    = (state_q == Idle) | mem_ack;

   always_comb begin
      gnt_vld = 1'b1;
      gnt_own = OwnerData;
      if (data_req && (cnt_q < LIMIT)) begin
         gnt_own = OwnerData;
      end else if (inst_elig) begin
         gnt_own = OwnerInst;
      end else if (data_req) begin
         gnt_own = OwnerData;
      end else begin
         gnt_vld = 1'b0;
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (arb_en && gnt_vld) begin
         if (gnt_own == OwnerInst) begin
            cnt_d = '0;
         end else if (inst_elig && (cnt_q < LIMIT)) begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= Idle;
         cnt_q   <= '0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         be_q    <= '0;
         addr_q  <= '0;
         wd_q    <= '0;
      end else begin
         cnt_q <= cnt_d;
         if (arb_en) begin
            if (!gnt_vld) begin
               state_q <= Idle;
               rd_q    <= 1'b0;
               wr_q    <= 1'b0;
               be_q    <= '0;
               addr_q  <= '0;
               wd_q    <= '0;
            end else if (gnt_own == OwnerInst) begin
               state_q <= InstBusy;
               rd_q    <= 1'b1;
               wr_q    <= 1'b0;
               be_q    <= '1;
               addr_q  <= inst_addr;
               wd_q    <= '0;
            end else begin
               state_q <= DataBusy;
               rd_q    <= ~data_wr_en;
               wr_q    <= data_wr_en;
               be_q    <= data_wr_en ? data_byte_en : '1;
               addr_q  <= data_addr;
               wd_q    <= data_wr_en ? data_wr_data : '0;
            end
         end else if ((state_q == InstBusy) && inst_flush) begin
            state_q <= InstDrop;
         end
      end
   end

   assign mem_rd_en    = rd_q;
   assign mem_wr_en    = wr_q;
   assign mem_byte_en  = be_q;
   assign mem_addr     = addr_q;
   assign mem_wr_data  = wd_q;

   assign inst_ack     = (state_q == InstBusy) & mem_ack & ~inst_flush;
   assign data_ack     = (state_q == DataBusy) & mem_ack;
   assign inst_rd_data = mem_rd_data;
   assign data_rd_data = mem_rd_data;

   assign wait_if      = inst_rd_en & ~inst_ack & ~inst_flush;
   assign wait_mem     = data_req & ~data_ack;

endmodule
